// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: synchronises N_SRC lines, keeps pending/mask/edge
// state, raises irq_out to the core and tracks the in-service source until EOI.
module irq_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [2:0]       bus_addr,
  input  logic [15:0]      bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [15:0]      bus_rdata,
  output logic             irq_out,
  input  logic             irq_ack,
  output logic [ID_W-1:0]  irq_id
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] s1, s2, prev;
  logic [N_SRC-1:0] pending, pending_next;
  logic [N_SRC-1:0] mask, edge_mode;
  logic [N_SRC-1:0] rise, active, ack_clr, set_bits, clr_bits, entering_edge;
  logic             in_service_valid;
  logic [ID_W-1:0]  in_service_id;
  logic             wr_pend, wr_mask, wr_edge, wr_eoi, wr_swi, ack_fire;
  logic [15:0]      rd_val;
  logic             unused_wdata;

  assign unused_wdata = ^bus_wdata;

  assign wr_pend  = bus_we && (bus_addr == 3'd0);
  assign wr_mask  = bus_we && (bus_addr == 3'd1);
  assign wr_edge  = bus_we && (bus_addr == 3'd2);
  assign wr_eoi   = bus_we && (bus_addr == 3'd4);
  assign wr_swi   = bus_we && (bus_addr == 3'd5);

  assign rise     = s2 & ~prev;
  assign active   = pending & mask;
  assign ack_fire = (state == REQ) && irq_ack;

  function automatic logic [ID_W-1:0] prio(input logic [N_SRC-1:0] a);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (a[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  // A bit switched into edge mode starts clean so a level that is already high
  // does not carry over as a pending edge.
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_fire && (irq_id == ID_W'(i));
    end
    entering_edge = wr_edge ? (bus_wdata[N_SRC-1:0] & ~edge_mode) : '0;
    set_bits      = rise | (wr_swi ? bus_wdata[N_SRC-1:0] : '0);
    clr_bits      = ack_clr | entering_edge | (wr_pend ? bus_wdata[N_SRC-1:0] : '0);
    pending_next  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (edge_mode[i] || entering_edge[i]) begin
        if (set_bits[i])      pending_next[i] = 1'b1;
        else if (clr_bits[i]) pending_next[i] = 1'b0;
        else                  pending_next[i] = pending[i];
      end else begin
        pending_next[i] = s2[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      s1      <= irq_src;
      s2      <= s1;
      prev    <= s2;
      pending <= pending_next;
      if (wr_mask) mask      <= bus_wdata[N_SRC-1:0];
      if (wr_edge) edge_mode <= bus_wdata[N_SRC-1:0];
    end
  end

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      3'd0: rd_val[N_SRC-1:0] = pending;
      3'd1: rd_val[N_SRC-1:0] = mask;
      3'd2: rd_val[N_SRC-1:0] = edge_mode;
      3'd3: begin
        rd_val[15]         = in_service_valid;
        rd_val[ID_W-1:0]   = in_service_id;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus_rdata <= '0;
    else if (bus_re) bus_rdata <= rd_val;
  end

  // Ack in REQ wins over everything else that cycle, including an EOI write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      irq_out          <= 1'b0;
      irq_id           <= '0;
      in_service_valid <= 1'b0;
      in_service_id    <= '0;
    end else begin
      if (wr_eoi) in_service_valid <= 1'b0;
      case (state)
        IDLE: begin
          irq_out <= 1'b0;
          if ((active != '0) && !in_service_valid) begin
            irq_id  <= prio(active);
            irq_out <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            in_service_valid <= 1'b1;
            in_service_id    <= irq_id;
            irq_out          <= 1'b0;
            state            <= SERVICE;
          end else if (active == '0) begin
            irq_out <= 1'b0;
            state   <= IDLE;
          end else begin
            irq_out <= 1'b1;
            irq_id  <= prio(active);
          end
        end
        SERVICE: begin
          irq_out <= 1'b0;
          if (wr_eoi) state <= IDLE;
        end
        default: begin
          irq_out <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: each task drives one scenario and checks
// the hand-computed response inline.
module tb_irq_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic [2:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_we;
  logic        bus_re;
  logic [15:0] bus_rdata;
  logic        irq_out;
  logic        irq_ack;
  logic [2:0]  irq_id;

  int errors = 0;
  int checks = 0;

  irq_ctrl #(.N_SRC(8), .ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_rdata (bus_rdata),
    .irq_out   (irq_out),
    .irq_ack   (irq_ack),
    .irq_id    (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick(1);
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    bus_addr = a;
    bus_re   = 1'b1;
    tick(1);
    bus_re   = 1'b0;
    d        = bus_rdata;
  endtask

  task automatic ack_pulse;
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] d;
    rst = 1'b1;
    tick(3);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out: got %0b want 0", irq_out); end
    checks++; if (bus_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus_rdata); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_irq_id: got %0d want 0", irq_id); end
    rst = 1'b0;
    tick(1);
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h want 0000", d); end
  endtask

  task automatic test_edge_latency;
    logic [15:0] d;
    bus_write(3'd1, 16'h0001);
    bus_write(3'd2, 16'h0001);
    irq_src[0] = 1'b1;
    tick(2);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL lat_k1: got %0b want 0", irq_out); end
    tick(1);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL lat_k2: got %0b want 0", irq_out); end
    bus_read(3'd0, d);
    irq_src[0] = 1'b0;
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL lat_pend: got %h want 0001", d); end
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL lat_k3: got %0b want 1", irq_out); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL lat_id: got %0d want 0", irq_id); end
    ack_pulse();
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL lat_ack_drop: got %0b want 0", irq_out); end
    bus_read(3'd3, d);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL lat_isr: got %h want 8000", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lat_pend_clr: got %h want 0000", d); end
    bus_write(3'd4, 16'h0000);
  endtask

  task automatic test_priority;
    logic [15:0] d;
    bus_write(3'd1, 16'h00FF);
    bus_write(3'd2, 16'h00FF);
    irq_src[5] = 1'b1;
    irq_src[2] = 1'b1;
    tick(4);
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL prio_req: got %0b want 1", irq_out); end
    checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL prio_id2: got %0d want 2", irq_id); end
    ack_pulse();
    bus_read(3'd3, d);
    checks++; if (d !== 16'h8002) begin errors++; $display("FAIL prio_isr2: got %h want 8002", d); end
    bus_write(3'd4, 16'h0000);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL prio_eoi_idle: got %0b want 0", irq_out); end
    tick(1);
    checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL prio_next_req: got %0b want 1", irq_out); end
    checks++; if (irq_id !== 3'd5) begin errors++; $display("FAIL prio_id5: got %0d want 5", irq_id); end
    ack_pulse();
    bus_read(3'd3, d);
    checks++; if (d !== 16'h8005) begin errors++; $display("FAIL prio_isr5: got %h want 8005", d); end
    irq_src[5] = 1'b0;
    irq_src[2] = 1'b0;
    bus_write(3'd4, 16'h0000);
    tick(4);
  endtask

  task automatic test_level;
    logic [15:0] d;
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h0008);
    irq_src[3] = 1'b1;
    tick(4);
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL lvl_req: got out=%0b id=%0d want out=1 id=3", irq_out, irq_id); end
    ack_pulse();
    bus_write(3'd4, 16'h0000);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL lvl_eoi: got %0b want 0", irq_out); end
    tick(1);
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd3) begin errors++; $display("FAIL lvl_rereq: got out=%0b id=%0d want out=1 id=3", irq_out, irq_id); end
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0008) begin errors++; $display("FAIL lvl_w1c_ignored: got %h want 0008", d); end
    irq_src[3] = 1'b0;
    tick(3);
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL lvl_drop: got %h want 0000", d); end
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL lvl_idle: got %0b want 0", irq_out); end
  endtask

  task automatic test_mask_withdraw;
    logic [15:0] d;
    bus_write(3'd2, 16'h0002);
    bus_write(3'd1, 16'h0002);
    irq_src[1] = 1'b1;
    tick(4);
    irq_src[1] = 1'b0;
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL mask_req: got out=%0b id=%0d want out=1 id=1", irq_out, irq_id); end
    bus_write(3'd1, 16'h0000);
    tick(1);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL mask_drop: got %0b want 0", irq_out); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL mask_pend_kept: got %h want 0002", d); end
    bus_write(3'd1, 16'h0002);
    tick(1);
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd1) begin errors++; $display("FAIL mask_reenable: got out=%0b id=%0d want out=1 id=1", irq_out, irq_id); end
    ack_pulse();
    bus_write(3'd4, 16'h0000);
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    bus_write(3'd2, 16'h0010);
    bus_write(3'd1, 16'h0010);
    bus_write(3'd5, 16'h0010);
    tick(1);
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd4) begin errors++; $display("FAIL swi_req: got out=%0b id=%0d want out=1 id=4", irq_out, irq_id); end
    irq_ack   = 1'b1;
    bus_addr  = 3'd0;
    bus_wdata = 16'h0010;
    bus_we    = 1'b1;
    tick(1);
    irq_ack   = 1'b0;
    bus_we    = 1'b0;
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL swi_ack_drop: got %0b want 0", irq_out); end
    bus_read(3'd3, d);
    checks++; if (d !== 16'h8004) begin errors++; $display("FAIL swi_isr: got %h want 8004", d); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL swi_pend_clr: got %h want 0000", d); end
    bus_read(3'd5, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL swi_read_zero: got %h want 0000", d); end
    bus_addr  = 3'd1;
    bus_wdata = 16'h0030;
    bus_we    = 1'b1;
    bus_re    = 1'b1;
    tick(1);
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    checks++; if (bus_rdata !== 16'h0010) begin errors++; $display("FAIL rw_same_old: got %h want 0010", bus_rdata); end
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0030) begin errors++; $display("FAIL rw_same_new: got %h want 0030", d); end
  endtask

  task automatic test_async_reset;
    logic [15:0] d;
    irq_src[6] = 1'b1;
    bus_read(3'd1, d);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL arst_irq_out: got %0b want 0", irq_out); end
    checks++; if (bus_rdata !== 16'h0000) begin errors++; $display("FAIL arst_rdata: got %h want 0000", bus_rdata); end
    tick(1);
    rst = 1'b0;
    tick(1);
    bus_read(3'd1, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_mask: got %h want 0000", d); end
    ack_pulse();
    bus_read(3'd3, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_isr: got %h want 0000", d); end
    bus_write(3'd2, 16'h0040);
    bus_write(3'd1, 16'h0040);
    tick(5);
    checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL arst_no_retrig: got %0b want 0", irq_out); end
    bus_read(3'd0, d);
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL arst_pend: got %h want 0000", d); end
    irq_src[6] = 1'b0;
    tick(3);
    irq_src[6] = 1'b1;
    tick(4);
    checks++; if (irq_out !== 1'b1 || irq_id !== 3'd6) begin errors++; $display("FAIL arst_reedge: got out=%0b id=%0d want out=1 id=6", irq_out, irq_id); end
  endtask

  initial begin
    rst       = 1'b1;
    irq_src   = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    irq_ack   = 1'b0;
    #2;
    test_reset();
    test_edge_latency();
    test_priority();
    test_level();
    test_mask_withdraw();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Prioritised interrupt controller directly upstream of the special-register/paging unit.
- Collects N_SRC external interrupt lines (timer, UART, SPI, ...) and raises a single request, irq_out, that drives the core's irq_in.
- Holds the request until the core accepts it via irq_ack, then records the in-service source until software writes EOI.
- Software accesses it through a small word-addressed register port on the I/O bus.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16).
- ID_W, 3, width of the source id; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- irq_src  in  N_SRC  raw asynchronous interrupt lines, active-high.
- bus_addr  in  3  register select.
- bus_wdata  in  16  write data.
- bus_we  in  1  write strobe, one cycle per access.
- bus_re  in  1  read strobe, one cycle per access.
- bus_rdata  out  16  read data, registered.
- irq_out  out  1  request to core (irq_in), registered.
- irq_ack  in  1  one-cycle pulse; core took the interrupt (irq_in & irq_en & pc update).
- irq_id  out  ID_W  id of the highest-priority active source, registered.

Behaviour:
- Reset: all of the following clear to 0: synchronisers, pending, MASK, EDGE, in-service, bus_rdata, irq_out, irq_id. State = IDLE.
- Input path: each irq_src passes through a 2-flop synchroniser (s1, s2) plus a previous-value flop for edge detection.
- Edge source (EDGE[i]=1):
  - pending[i] sets on s2 rising.
  - pending[i] clears on write-1 to PEND or on ack capture of i.
  - If set and clear occur in the same cycle, set wins.
- Level source (EDGE[i]=0):
  - pending[i] = s2[i], registered.
  - Write-1-clear and ack have no effect.
- Latency: an irq_src rise sampled at edge k gives pending at edge k+2 and irq_out=1 at edge k+3, provided the source is unmasked and state is IDLE.
- Active set: active = pending & MASK. Priority is fixed: lowest index wins.
- Register map, bus_addr:
  - 0 PEND: R returns pending. W: 1 bits clear edge-pending bits.
  - 1 MASK: R/W; 1 = enabled.
  - 2 EDGE: R/W; 1 = edge-triggered.
  - 3 ISR: R = {in_service_valid, 15-ID_W zeros, in_service_id}. W ignored.
  - 4 EOI: W any value clears in_service_valid. R = 0.
  - 5 SWI: W 1 bits set pending (soft interrupt; pending stays set for edge sources only). R = 0.
  - 6, 7: R = 0, W ignored.
  - Bits above N_SRC read 0.
- Bus timing:
  - bus_rdata is updated on the edge where bus_re=1 and is valid the following cycle. It holds until the next read.
  - Write and read to the same address in the same cycle: read returns the old value.
- FSM:
  - IDLE:
    - irq_out=0.
    - If active != 0 and in_service_valid=0: latch irq_id = priority(active) and go to REQ.
  - REQ:
    - irq_out=1; irq_id is re-evaluated every cycle from active.
    - If irq_ack=1: capture in_service_id = irq_id, set in_service_valid=1, clear pending[irq_id] if it is edge-type, drop irq_out, go to SERVICE. Ack has precedence over every other condition in the same cycle.
    - Else if active becomes 0 (masked or cleared): drop irq_out, go to IDLE.
  - SERVICE:
    - irq_out=0; further interrupts are held pending (no nesting).
    - On EOI write, go to IDLE. A new request may issue on the next cycle.
- irq_ack in IDLE or SERVICE: ignored.
- EOI while in IDLE or REQ: clears in_service_valid only; state is unchanged.
- Asynchronous reset mid-REQ or mid-SERVICE: irq_out drops immediately and all state clears. Sources must re-edge after reset to become pending again.

Test Plan:
- Reset, MASK=0x01, EDGE=0x01, pulse irq_src[0] for 3 cycles -> pending[0]=1 at k+2, irq_out=1 at k+3, irq_id=0; after irq_ack pulse: irq_out=0, ISR reads 0x8000, PEND reads 0x00.
- MASK=0xFF, EDGE=0xFF, raise src[5] and src[2] in the same cycle -> irq_id=2. Ack, then EOI -> next cycle back in IDLE, then irq_out=1 with irq_id=5. Ack -> ISR reads 0x8005.
- Level source 3 (EDGE=0), MASK=0x08, hold src[3] high -> after ack and EOI, irq_out re-asserts with irq_id=3. Write PEND=0x08 -> pending[3] stays 1. Drop src[3] -> PEND reads 0 two cycles later.
- In REQ with src[1] (edge) pending, write MASK=0x00 -> irq_out=0 the next cycle, state returns to IDLE, PEND still reads 0x02. Re-enable MASK=0x02 -> irq_out=1 again.
- Write SWI=0x10 with EDGE=0x10, MASK=0x10 -> irq_out=1 with irq_id=4. In the same cycle, drive irq_ack and a write of PEND=0x10 -> enters SERVICE with ISR=0x8004 and pending[4] cleared.
- Assert rst asynchronously while in SERVICE -> irq_out, bus_rdata, MASK and ISR all read 0. A held-high edge source does not re-trigger until it falls and rises again.
